// File: rtl/sampstream_arb.sv
// sampstream_arb: round-robin burst arbiter for sample streams with a wishbone control port.
// Define SAMPSTREAM_ARB_STATS_EN to compile in per-requester 16-bit pull counters.
module sampstream_arb #(
  parameter int NUM_REQ = 4,
  parameter int CHAN_W  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*NUM_REQ-1:0] in_data,
  input  logic [8*NUM_REQ-1:0]  in_count,
  input  logic [NUM_REQ-1:0]    in_avail,
  output logic [NUM_REQ-1:0]    in_pull,
  output logic [31:0]           out_data,
  output logic [7:0]            out_count,
  output logic [CHAN_W-1:0]     out_chan,
  output logic                  out_avail,
  input  logic                  out_pull,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [15:0]           wb_adr_i,
  input  logic [7:0]            wb_dat_i,
  output logic [7:0]            wb_dat_o,
  output logic                  wb_ack_o
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CHAN_W-1:0]   grant_q, grant_d;
  logic [CHAN_W-1:0]   last_q, last_d;
  logic [7:0]          left_q, left_d;
  logic [NUM_REQ-1:0]  en_q, en_d;

  logic [31:0]         data_a [NUM_REQ];
  logic [7:0]          cnt_a [NUM_REQ];
  logic [NUM_REQ-1:0]  nz;
  logic [NUM_REQ-1:0]  elig;
  logic                found;
  logic [CHAN_W-1:0]   pick;
  logic [CHAN_W-1:0]   cand;
  logic                wr;
  logic [3:0]          adr;
  logic                unused_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_a[g] = in_data[32*g +: 32];
    assign cnt_a[g]  = in_count[8*g +: 8];
    assign nz[g]     = |cnt_a[g];
  end

  assign elig      = in_avail & en_q & nz;
  assign wr        = wb_cyc_i & wb_stb_i & wb_we_i;
  assign adr       = wb_adr_i[3:0];
  assign wb_ack_o  = 1'b1;
  assign unused_ok = &{1'b0, wb_adr_i[15:4], wb_dat_i};

  // Round-robin search upward from the requester after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = CHAN_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CHAN_W'(NUM_REQ - 1);
      left_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      left_q  <= left_d;
      en_q    <= en_d;
    end
  end

  // Next-state: grant in IDLE, count words down in BURST.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    left_d  = left_q;
    en_d    = en_q;
    if (wr && adr == 4'd0) en_d = wb_dat_i[NUM_REQ-1:0];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          left_d  = cnt_a[pick];
          state_d = BURST;
        end
      end
      BURST: begin
        if (out_pull) begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream outputs; pops are held off while reset is asserted.
  always_comb begin
    out_avail = 1'b0;
    out_chan  = grant_q;
    out_count = left_q;
    out_data  = data_a[grant_q];
    in_pull   = '0;
    if (state_q == BURST) begin
      out_avail = 1'b1;
      if (!rst) in_pull[grant_q] = out_pull;
    end
  end

`ifdef SAMPSTREAM_ARB_STATS_EN
  logic [7:0] stat_b [8];
  logic       clr;

  assign clr = wr && adr == 4'd1;

  for (genvar g = 0; g < 4; g++) begin : g_stat
    if (g < NUM_REQ) begin : g_on
      logic [15:0] cnt_q, cnt_d;
      // Count pops; a clear in the same cycle wins.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) cnt_d = '0;
        else if (in_pull[g]) cnt_d = cnt_q + 16'd1;
      end
      // Counter register.
      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
      end
      assign stat_b[2*g]   = cnt_q[7:0];
      assign stat_b[2*g+1] = cnt_q[15:8];
    end else begin : g_off
      assign stat_b[2*g]   = '0;
      assign stat_b[2*g+1] = '0;
    end
  end
`endif

  // Register read mux; unmapped addresses read zero.
  always_comb begin
    wb_dat_o = '0;
    unique case (1'b1)
      (adr == 4'd0): wb_dat_o[NUM_REQ-1:0] = en_q;
      (adr == 4'd1): begin
        wb_dat_o[0]          = (state_q == BURST);
        wb_dat_o[4 +: CHAN_W] = grant_q;
      end
`ifdef SAMPSTREAM_ARB_STATS_EN
      adr[3]: wb_dat_o = stat_b[adr[2:0]];
`endif
      default: wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_sampstream_arb.sv
// tb_sampstream_arb: scoreboard bench for sampstream_arb.
// Requesters are modelled as FIFOs that pop on in_pull.
module tb_sampstream_arb;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [32*N-1:0] in_data;
  logic [8*N-1:0]  in_count;
  logic [N-1:0]  in_avail;
  logic [N-1:0]  in_pull;
  logic [31:0]   out_data;
  logic [7:0]    out_count;
  logic [CW-1:0] out_chan;
  logic          out_avail;
  logic          out_pull;
  logic          wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0]   wb_adr_i;
  logic [7:0]    wb_dat_i, wb_dat_o;
  logic          wb_ack_o;

  int   rem [N];
  int   seq [N];
  int   exp_seq [N];
  int   pulls [N];
  bit   force_av [N];
  logic [63:0] sb [$];
  int   glog [$];
  int   checks = 0;
  int   failures = 0;
  logic prev_av = 1'b0;

  sampstream_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_count(in_count),
    .in_avail(in_avail), .in_pull(in_pull),
    .out_data(out_data), .out_count(out_count),
    .out_chan(out_chan), .out_avail(out_avail),
    .out_pull(out_pull),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data  = '0;
    in_count = '0;
    in_avail = '0;
    for (int i = 0; i < N; i++) begin
      in_data[32*i +: 32] = {8'(i), 8'h5A, 16'(seq[i])};
      in_count[8*i +: 8]  = 8'(rem[i]);
      in_avail[i]         = force_av[i] || (rem[i] != 0);
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    logic [N-1:0] ep;
    logic [63:0]  e;
    ep = '0;
    if (!rst && out_avail && out_pull) ep[out_chan] = 1'b1;
    chk(rst ? "pull_rst" : "pull", 64'(in_pull), 64'(ep));
    if (!rst && out_avail && !prev_av) glog.push_back(int'(out_chan));
    if (!rst && out_avail && out_pull) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {out_chan, out_count, out_data}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("word", 64'({8'(out_chan), out_count, out_data}), e);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (in_pull[i]) begin
        rem[i]--;
        seq[i]++;
        pulls[i]++;
      end
    end
    prev_av = out_avail;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_burst(int ch, int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back({16'h0, 8'(ch), 8'(n - k), 8'(ch), 8'h5A, 16'(exp_seq[ch])});
      exp_seq[ch]++;
    end
  endtask

  task automatic wait_idle(string tag, int max);
    int n = 0;
    while ((sb.size() != 0 || out_avail) && n < max) begin
      step(1);
      n++;
    end
    chk(tag, 64'(sb.size() == 0 && !out_avail), 64'd1);
  endtask

  task automatic wait_avail(string tag, int max);
    int n = 0;
    while (!out_avail && n < max) begin
      step(1);
      n++;
    end
    chk(tag, 64'(out_avail), 64'd1);
  endtask

  task automatic wb_write(logic [15:0] a, logic [7:0] d);
    wb_adr_i = a; wb_dat_i = d;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    step(1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(logic [15:0] a, output logic [7:0] d);
    wb_adr_i = a;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    #1;
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int p;
    int eo [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; out_pull = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = '0; wb_dat_i = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; exp_seq[i] = 0;
      pulls[i] = 0; force_av[i] = 0;
    end
    step(2);
    rst = 1'b0;

    chk("rst_avail", 64'(out_avail), 64'd0);
    chk("ack", 64'(wb_ack_o), 64'd1);
    wb_read(16'h0, rd); chk("rst_mask", 64'(rd), 64'h00);
    wb_read(16'h1, rd); chk("rst_status", 64'(rd), 64'h00);

    // single burst, latency and pull count
    wb_write(16'h0, 8'h01);
    out_pull = 1'b1;
    push_burst(0, 3);
    p = pulls[0];
    rem[0] = 3;
    chk("lat_pre", 64'(out_avail), 64'd0);
    step(1);
    chk("lat_post", 64'(out_avail), 64'd1);
    wait_idle("b1_done", 20);
    chk("b1_pulls", 64'(pulls[0] - p), 64'd3);
    step(3);
    chk("b1_idle", 64'(out_avail), 64'd0);

    // round robin order 0,1,2,3,0
    do_reset();
    glog.delete();
    wb_write(16'h0, 8'h0F);
    push_burst(0, 2); push_burst(1, 2);
    push_burst(2, 2); push_burst(3, 2);
    push_burst(0, 2);
    for (int i = 0; i < N; i++) rem[i] = 2;
    p = 0;
    while (rem[0] != 0 && p < 50) begin
      step(1);
      p++;
    end
    chk("refill_to", 64'(rem[0] == 0), 64'd1);
    rem[0] = 2;
    wait_idle("rr_done", 100);
    chk("rr_n", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("rr_ord", 64'(i < glog.size() ? glog[i] : -1), 64'(eo[i]));

    // disabling mid-burst keeps the burst going
    out_pull = 1'b0;
    push_burst(1, 5);
    rem[1] = 5;
    wait_avail("dis_av", 10);
    chk("dis_chan", 64'(out_chan), 64'd1);
    chk("dis_cnt", 64'(out_count), 64'd5);
    wb_read(16'h1, rd); chk("busy_status", 64'(rd), 64'h11);
    wb_write(16'h0, 8'h00);
    p = pulls[1];
    out_pull = 1'b1;
    wait_idle("dis_done", 20);
    chk("dis_pulls", 64'(pulls[1] - p), 64'd5);
    rem[1] = 3;
    step(5);
    chk("dis_nogrant", 64'(out_avail), 64'd0);
    chk("dis_nopull", 64'(pulls[1] - p), 64'd5);
    rem[1] = 0;

    // reset aborts a burst; first grant afterwards is requester 0
    wb_write(16'h0, 8'h0F);
    out_pull = 1'b0;
    rem[2] = 4;
    wait_avail("abort_av", 10);
    chk("abort_chan", 64'(out_chan), 64'd2);
    chk("abort_cnt", 64'(out_count), 64'd4);
    rst = 1'b1;
    out_pull = 1'b1;
    step(1);
    chk("abort_avail", 64'(out_avail), 64'd0);
    rst = 1'b0;
    wb_read(16'h0, rd); chk("abort_mask", 64'(rd), 64'h00);
    push_burst(0, 1); push_burst(2, 4); push_burst(3, 1);
    rem[0] = 1; rem[3] = 1;
    glog.delete();
    wb_write(16'h0, 8'h0F);
    wait_idle("post_rst_done", 60);
    chk("post_rst_n", 64'(glog.size()), 64'd3);
    chk("post_rst_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);

    // zero count requester never granted
    force_av[1] = 1'b1;
    glog.delete();
    push_burst(3, 2);
    rem[3] = 2;
    wait_idle("zc_done", 30);
    step(5);
    chk("zc_n", 64'(glog.size()), 64'd1);
    chk("zc_chan", 64'(glog.size() > 0 ? glog[0] : -1), 64'd3);
    chk("zc_idle", 64'(out_avail), 64'd0);
    wb_read(16'h1, rd); chk("zc_status", 64'(rd), 64'h30);
    force_av[1] = 1'b0;

    // register map boundaries
    wb_write(16'h0, 8'hFF);
    wb_read(16'h0, rd); chk("mask_bits", 64'(rd), 64'h0F);
    wb_write(16'h2, 8'hFF);
    wb_read(16'h2, rd); chk("unused_rd", 64'(rd), 64'h00);
    wb_write(16'h1, 8'h00);
    wb_read(16'h0, rd); chk("ro_write", 64'(rd), 64'h0F);

`ifdef SAMPSTREAM_ARB_STATS_EN
    wb_write(16'h1, 8'h00);
    wb_read(16'hC, rd); chk("st_clr0", 64'(rd), 64'h00);
    wb_write(16'h0, 8'h04);
    push_burst(2, 10);
    rem[2] = 10;
    wait_idle("st_done", 40);
    wb_read(16'hC, rd); chk("st_lo", 64'(rd), 64'h0A);
    wb_read(16'hD, rd); chk("st_hi", 64'(rd), 64'h00);
    wb_read(16'h8, rd); chk("st_r0", 64'(rd), 64'h00);
    wb_write(16'h1, 8'h00);
    wb_read(16'hC, rd); chk("st_clr", 64'(rd), 64'h00);
`else
    wb_read(16'hC, rd); chk("nost_c", 64'(rd), 64'h00);
    wb_read(16'h9, rd); chk("nost_9", 64'(rd), 64'h00);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
